// File: rtl/conv_1x1_channel_mac_11_pkg.sv
// Shared definitions for the 1x1 convolution channel MAC: FSM encoding and
// saturation limits derived from the datapath word width.
package conv_1x1_channel_mac_11_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Limits are computed in a wide signed type so they compare directly
    // against the sign-extended, shifted accumulator.
    localparam int SAT_CALC_W = 128;
    typedef logic signed [SAT_CALC_W-1:0] sat_wide_t;

    function automatic sat_wide_t satMax(input int dataWidth);
        return (sat_wide_t'(1) <<< (dataWidth - 1)) - sat_wide_t'(1);
    endfunction

    function automatic sat_wide_t satMin(input int dataWidth);
        return -(sat_wide_t'(1) <<< (dataWidth - 1));
    endfunction

endpackage

// File: rtl/conv_1x1_channel_mac_11_mac_sat.sv
// Three-stage datapath: signed product, per-pixel accumulate, then
// fixed-point rescale with saturation into the registered result.
module conv_1x1_mac_sat
    import conv_1x1_channel_mac_11_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int IN_CHANNELS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_beatValid,
    input  logic                         i_beatFirst,
    input  logic                         i_beatLast,
    input  logic signed [DATA_WIDTH-1:0] i_feature,
    input  logic signed [DATA_WIDTH-1:0] i_weight,
    output logic        [DATA_WIDTH-1:0] o_result,
    output logic                         o_resultValid
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(IN_CHANNELS);
    localparam sat_wide_t SAT_MAX = satMax(DATA_WIDTH);
    localparam sat_wide_t SAT_MIN = satMin(DATA_WIDTH);

    logic signed [PROD_W-1:0]     r_prod;
    logic                         r_prodValid;
    logic                         r_prodFirst;
    logic                         r_prodLast;
    logic signed [ACC_W-1:0]      r_acc;
    logic                         r_accDone;
    logic signed [ACC_W-1:0]      w_shifted;
    sat_wide_t                    w_shiftedWide;
    logic        [DATA_WIDTH-1:0] w_saturated;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod      <= '0;
            r_prodValid <= 1'b0;
            r_prodFirst <= 1'b0;
            r_prodLast  <= 1'b0;
        end else begin
            r_prodValid <= i_beatValid && !i_flush;
            if (i_beatValid) begin
                r_prod      <= PROD_W'(i_feature) * PROD_W'(i_weight);
                r_prodFirst <= i_beatFirst;
                r_prodLast  <= i_beatLast;
            end
        end
    end

    // The first channel of a pixel reloads the sum instead of adding to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_accDone <= 1'b0;
        end else begin
            r_accDone <= r_prodValid && r_prodLast && !i_flush;
            if (r_prodValid) begin
                r_acc <= r_prodFirst ? ACC_W'(r_prod) : r_acc + ACC_W'(r_prod);
            end
        end
    end

    assign w_shifted     = r_acc >>> FRAC_BITS;
    assign w_shiftedWide = sat_wide_t'(w_shifted);

    always_comb begin
        w_saturated = w_shiftedWide[DATA_WIDTH-1:0];
        if (w_shiftedWide > SAT_MAX) begin
            w_saturated = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shiftedWide < SAT_MIN) begin
            w_saturated = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_result      <= '0;
            o_resultValid <= 1'b0;
        end else begin
            o_resultValid <= r_accDone && !i_flush;
            if (r_accDone && !i_flush) begin
                o_result <= w_saturated;
            end
        end
    end

endmodule

// File: rtl/conv_1x1_channel_mac_11.sv
// 1x1 convolution channel MAC: loads IN_CHANNELS weights from a FIFO, then
// computes one saturated fixed-point dot product per pixel of channel beats.
module conv_1x1_channel_mac_11
    import conv_1x1_channel_mac_11_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int IN_CHANNELS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  load_weights,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out
);

    localparam int CH_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int LC_W = $clog2(IN_CHANNELS + 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(IN_CHANNELS - 1);
    localparam logic [LC_W-1:0] LOAD_DONE = LC_W'(IN_CHANNELS);

    state_t                r_state;
    state_t                w_nextState;
    logic [LC_W-1:0]       r_loadCnt;
    logic [CH_W-1:0]       r_ch;
    logic [DATA_WIDTH-1:0] r_weight [IN_CHANNELS];
    logic [CH_W-1:0]       w_wrIdx;
    logic                  w_accept;
    logic                  w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // LOAD spans IN_CHANNELS read cycles plus one trailing capture cycle,
    // since FIFO data arrives one cycle behind its read enable.
    always_comb begin
        w_nextState  = r_state;
        load_weights = 1'b0;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_nextState = LOAD;
            end
            LOAD: begin
                load_weights = (r_loadCnt != LOAD_DONE);
                if (r_loadCnt == LOAD_DONE) w_nextState = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (start) w_nextState = LOAD;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept = valid_in && in_ready;
    assign w_flush  = (r_state == RUN) && start;
    assign w_wrIdx  = CH_W'(r_loadCnt - LC_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loadCnt <= '0;
            r_ch      <= '0;
        end else begin
            if (r_state != LOAD) begin
                r_loadCnt <= '0;
            end else if (r_loadCnt != LOAD_DONE) begin
                r_loadCnt <= r_loadCnt + LC_W'(1);
            end

            if (r_state != RUN || start) begin
                r_ch <= '0;
            end else if (w_accept) begin
                r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    // Weights carry no reset; they are meaningful only after a full LOAD.
    always_ff @(posedge clk) begin
        if (r_state == LOAD && r_loadCnt != '0) begin
            r_weight[w_wrIdx] <= weight_in;
        end
    end

    conv_1x1_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .IN_CHANNELS(IN_CHANNELS)
    ) u_macSat (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (w_flush),
        .i_beatValid  (w_accept),
        .i_beatFirst  (r_ch == '0),
        .i_beatLast   (r_ch == LAST_CH),
        .i_feature    (in),
        .i_weight     (r_weight[r_ch]),
        .o_result     (out),
        .o_resultValid(valid_out)
    );

endmodule

// File: tb/tb_conv_1x1_channel_mac_11.sv
// Directed bench for the 1x1 channel MAC with four channels and Q16.16 words;
// every expected value is hand-computed.
module tb_conv_1x1_channel_mac_11;
    import conv_1x1_channel_mac_11_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] weightIn;
    logic        loadWeights;
    logic        validIn;
    logic [31:0] featIn;
    logic        inReady;
    logic [31:0] dataOut;
    logic        validOut;

    int nAssert = 0;
    int nFail   = 0;
    int cycle   = 0;
    int lastBeatCyc;
    int pix1Cyc;
    logic [31:0] outQ[$];
    int          cycQ[$];

    conv_1x1_channel_mac_11 #(
        .DATA_WIDTH (32),
        .FRAC_BITS  (16),
        .IN_CHANNELS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .weight_in   (weightIn),
        .load_weights(loadWeights),
        .valid_in    (validIn),
        .in          (featIn),
        .in_ready    (inReady),
        .out         (dataOut),
        .valid_out   (validOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Records every valid_out cycle together with its cycle stamp.
    always @(negedge clk) begin
        if (validOut) begin
            outQ.push_back(dataOut);
            cycQ.push_back(cycle);
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input int gap);
        validIn     = 1'b1;
        featIn      = data;
        lastBeatCyc = cycle;
        tick();
        validIn = 1'b0;
        repeat (gap) tick();
    endtask

    // Acts as the weight FIFO: each read enable yields a word one cycle later.
    task automatic applyLoad(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input bit pokeStart);
        logic [31:0] wq[4];
        int  loads;
        int  loadCycles;
        int  k;
        bit  prevLoad;
        bit  done;
        wq = '{w0, w1, w2, w3};
        loads = 0; loadCycles = 0; k = 0; done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (inReady) begin
                done = 1'b1;
            end else begin
                prevLoad = loadWeights;
                if (loadWeights) loads++;
                loadCycles++;
                start = pokeStart && (i == 2);
                tick();
                start = 1'b0;
                if (prevLoad && k < 4) begin
                    weightIn = wq[k];
                    k++;
                end else begin
                    weightIn = '0;
                end
            end
        end
        checkOutput("load_cycles", loads, 4);
        checkOutput("load_to_run", loadCycles, 5);
        checkOutput("run_in_ready", inReady, 1);
    endtask

    task automatic checkPixel(input string tag, input logic [31:0] expVal);
        repeat (5) tick();
        checkOutput({tag, "_pulses"}, outQ.size(), 1);
        checkOutput({tag, "_value"}, (outQ.size() > 0) ? outQ[0] : 'x, expVal);
        checkOutput({tag, "_latency"}, (cycQ.size() > 0) ? cycQ[0] - lastBeatCyc : -1, 3);
        checkOutput({tag, "_hold"}, dataOut, expVal);
        outQ.delete();
        cycQ.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; weightIn = '0; validIn = 1'b0; featIn = '0;
        repeat (3) tick();
        checkOutput("rst_out", dataOut, 0);
        checkOutput("rst_valid_out", validOut, 0);
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_load_weights", loadWeights, 0);
        checkOutput("rst_state", dut.r_state, IDLE);
        checkOutput("rst_ch", dut.r_ch, 0);
        reset = 1'b0;

        $display("[TB] valid_in while idle is ignored");
        for (int i = 0; i < 3; i++) applyStimulus(32'h0005_0000, 0);
        repeat (4) tick();
        checkOutput("idle_no_valid_out", outQ.size(), 0);
        checkOutput("idle_state", dut.r_state, IDLE);

        $display("[TB] unit weights, features 1..4");
        applyLoad(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        applyStimulus(32'h0001_0000, 0);
        applyStimulus(32'h0002_0000, 0);
        applyStimulus(32'h0003_0000, 0);
        applyStimulus(32'h0004_0000, 0);
        checkPixel("unit", 32'h000A_0000);

        $display("[TB] negative weights, start poked during load");
        applyLoad(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0002_0000, 0);
        checkPixel("neg", 32'hFFF8_0000);

        $display("[TB] saturation both directions");
        applyLoad(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h7FFF_FFFF, 0);
        checkPixel("sat_pos", 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) applyStimulus(32'h8000_0001, 0);
        checkPixel("sat_neg", 32'h8000_0000);

        $display("[TB] two pixels with random gaps");
        applyLoad(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0000_8000, int'($urandom_range(0, 1)));
        pix1Cyc = lastBeatCyc;
        applyStimulus(32'h0001_0000, int'($urandom_range(0, 1)));
        applyStimulus(32'hFFFF_0000, int'($urandom_range(0, 1)));
        applyStimulus(32'h0003_0000, int'($urandom_range(0, 1)));
        applyStimulus(32'h0005_0000, 0);
        repeat (5) tick();
        checkOutput("gap_pulses", outQ.size(), 2);
        checkOutput("gap_pix1", (outQ.size() > 0) ? outQ[0] : 'x, 32'h0002_0000);
        checkOutput("gap_pix2", (outQ.size() > 1) ? outQ[1] : 'x, 32'h0008_0000);
        checkOutput("gap_lat1", (cycQ.size() > 0) ? cycQ[0] - pix1Cyc : -1, 3);
        checkOutput("gap_lat2", (cycQ.size() > 1) ? cycQ[1] - lastBeatCyc : -1, 3);
        checkOutput("gap_ch_zero", dut.r_ch, 0);
        outQ.delete();
        cycQ.delete();

        $display("[TB] start after two beats reloads weights");
        applyStimulus(32'h0001_0000, 0);
        applyStimulus(32'h0001_0000, 0);
        applyLoad(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0);
        checkOutput("abort_no_valid_out", outQ.size(), 0);
        checkOutput("abort_ch_zero", dut.r_ch, 0);
        applyStimulus(32'h0001_0000, 0);
        applyStimulus(32'h0002_0000, 0);
        applyStimulus(32'h0003_0000, 0);
        applyStimulus(32'h0004_0000, 0);
        checkPixel("reload", 32'h001E_0000);

        $display("[TB] reset in the middle of a pixel");
        for (int i = 0; i < 4; i++) applyStimulus(32'h0001_0000, 0);
        reset = 1'b1;
        tick();
        checkOutput("midrst_out", dataOut, 0);
        checkOutput("midrst_valid_out", validOut, 0);
        checkOutput("midrst_in_ready", inReady, 0);
        checkOutput("midrst_load_weights", loadWeights, 0);
        checkOutput("midrst_state", dut.r_state, IDLE);
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("midrst_no_valid_out", outQ.size(), 0);
        checkOutput("midrst_out_held", dataOut, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/conv_1x1_channel_mac_11.md
CONV_1X1_CHANNEL_MAC_11 -- requirements
Module: conv_1x1_channel_mac_11

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of feature, weight and result words.
REQ-002 Parameter FRAC_BITS, default 16: fractional bits of signed fixed-point words.
REQ-003 Parameter IN_CHANNELS, default 16: number of input channels per pixel, and number of weights held.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse requesting a weight (re)load.
REQ-007 weight_in  input  DATA_WIDTH  weight word from the weight buffer FIFO output.
REQ-008 load_weights  output  1  read enable to the weight buffer FIFO.
REQ-009 valid_in  input  1  feature beat valid; one channel value per beat, channel 0 first.
REQ-010 in  input  DATA_WIDTH  signed feature value.
REQ-011 in_ready  output  1  high only in RUN; beats are accepted only when valid_in and in_ready are both high.
REQ-012 out  output  DATA_WIDTH  signed dot product for one pixel.
REQ-013 valid_out  output  1  single-cycle pulse qualifying out.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN; reset enters IDLE.
REQ-015 IDLE: load_weights=0; start moves to LOAD next cycle.
REQ-016 LOAD: load_weights SHALL be high for exactly IN_CHANNELS consecutive cycles.
REQ-017 weight_in is valid one cycle after each load_weights cycle; the k-th such word SHALL be stored in weight register k (0..IN_CHANNELS-1).
REQ-018 The FSM SHALL enter RUN in the cycle after the last weight is captured.
REQ-019 RUN: the channel counter ch starts at 0 and increments per accepted beat; it wraps to 0 after IN_CHANNELS-1.
REQ-020 Each accepted beat SHALL form the full 2*DATA_WIDTH signed product in*weight[ch] in a product register (stage 1).
REQ-021 The product SHALL be added to an accumulator of width 2*DATA_WIDTH+clog2(IN_CHANNELS) (stage 2).
REQ-022 The accumulator SHALL restart from the product on ch==0 rather than add to the previous sum.
REQ-023 On the beat carrying ch==IN_CHANNELS-1, the result SHALL be computed as accumulator arithmetically shifted right by FRAC_BITS.
REQ-024 The result SHALL be saturated to the signed DATA_WIDTH range and registered to out.
REQ-025 valid_out SHALL pulse 3 cycles after the last-channel beat is accepted.
REQ-026 Gaps in valid_in are permitted anywhere and SHALL not corrupt the sum; back-to-back pixels SHALL run at full rate.
REQ-027 out SHALL hold its value between valid_out pulses.
REQ-028 start in LOAD SHALL be ignored.
REQ-029 start in RUN SHALL discard any partial pixel, cancel in-flight results (no valid_out), clear ch, and enter LOAD.
REQ-030 valid_in outside RUN SHALL be ignored.

Reset
REQ-031 Reset SHALL set the following to 0: state=IDLE, ch, load_weights, in_ready, valid_out, out, accumulator, pipeline valid bits.
REQ-032 Weight registers need not be reset; they are invalid until a LOAD completes.
REQ-033 Reset mid-LOAD or mid-pixel SHALL abort the operation with no valid_out pulse afterwards.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the saturation limit constants derived from DATA_WIDTH.
REQ-035 One sub-module, conv_1x1_mac_sat, SHALL implement the product/accumulate/shift/saturate datapath; the top holds the FSM, counters and weight registers.

Verification (IN_CHANNELS=4, FRAC_BITS=16, DATA_WIDTH=32)
REQ-036 Load weights all 0x00010000, then features 0x00010000, 0x00020000, 0x00030000, 0x00040000 -> out=0x000A0000 with valid_out 3 cycles after the 4th beat.
REQ-037 Weights 0xFFFF0000 (-1.0) and features all 0x00020000 -> out=0xFFF80000 (-8.0).
REQ-038 Weights 0x7FFFFFFF and features 0x7FFFFFFF -> out=0x7FFFFFFF; negated features -> 0x80000000.
REQ-039 Random one-cycle gaps between beats, two back-to-back pixels -> two correct results, two valid_out pulses, ch returns to 0.
REQ-040 start after 2 beats of a pixel -> no valid_out, load_weights high 4 cycles, new weights used for the next pixel.
REQ-041 reset asserted mid-pixel -> all outputs 0, state IDLE, in_ready=0, no later valid_out.
